axi3_line_master: RTL and testbench
===================================

# axi3_line_master

AXI3 burst master that moves whole cache lines between a simple line-request port and the `axi3_rd_if` / `axi3_wr_if` buses. It sits between the cache refill/write-back logic and the memory side. It turns one line read into one INCR read burst, and one line write into one INCR write burst plus its response. One transaction is in flight at a time.

## Interface
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, AXI data width. Must be a power of two and ≥8.
- LINE_WIDTH, 256, line width.
- BEATS = LINE_WIDTH/DATA_WIDTH is derived, and must satisfy 1 ≤ BEATS ≤ 16 (AXI3 len limit). Burst len field = BEATS-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- rd_req  in  1  line read request.
- rd_addr  in  ADDR_WIDTH  read line address.
- rd_ready  out  1  request accepted this cycle (handshake with rd_req).
- rd_line  out  LINE_WIDTH  assembled read line. Valid when rd_done=1.
- rd_done  out  1  one-cycle pulse when the read line is complete.
- wr_req  in  1  line write request.
- wr_addr  in  ADDR_WIDTH  write line address.
- wr_line  in  LINE_WIDTH  write data. Sampled at acceptance.
- wr_ready  out  1  write request accepted this cycle.
- wr_done  out  1  one-cycle pulse after the write response.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse on a read burst with an early or missing rlast.
- axi3_rd_if  master  AXI3 read channel: ar*, r* fields.
- axi3_wr_if  master  AXI3 write channel: aw*, w*, b* fields.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- IDLE:
  - rd_ready = rd_req and wr_ready = wr_req && !rd_req. Reads win when both are requested.
  - On accept, latch the address with the low log2(LINE_WIDTH/8) bits forced to 0, clear the beat counter, and go to RD_ADDR or WR_ADDR.
  - For a write, also latch wr_line into the shift/line buffer.
- RD_ADDR:
  - arvalid=1, araddr = latched address, arlen = BEATS-1.
  - Go to RD_DATA on arready.
- RD_DATA:
  - rready=1.
  - Each rvalid beat k writes rdata into rd_line[k*DATA_WIDTH +: DATA_WIDTH]; the counter increments.
  - If the beat carries rlast, or k == BEATS-1: go to IDLE and pulse rd_done the next cycle.
  - If the beat has rlast with k != BEATS-1, or k == BEATS-1 without rlast: also pulse err in the same cycle as rd_done.
- WR_ADDR:
  - awvalid=1, awaddr = latched address, awlen = BEATS-1.
  - Go to WR_DATA on awready.
- WR_DATA:
  - wvalid=1, wdata = line_buf[k*DATA_WIDTH +: DATA_WIDTH], wlast = (k == BEATS-1).
  - On wready, k increments. After the wlast beat is accepted, go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid, go to IDLE and pulse wr_done the next cycle. bresp is ignored.
- Constant request fields:
  - arid/awid/wid = 0.
  - arsize/awsize = log2(DATA_WIDTH/8).
  - arburst/awburst = 2'b01 (INCR).
  - wstrb = all ones.
  - lock/cache/prot = 0.
- Beat counter width is 4 bits. It never wraps within a legal burst.
- Ignored inputs: a request during a non-IDLE state is not accepted (rd_ready/wr_ready=0) and is not queued. Stray rvalid outside RD_DATA and bvalid outside WR_RESP are also ignored.

## Timing
- Reset (sync, at clk edge with rst=1) forces:
  - state=IDLE;
  - arvalid, awvalid, wvalid, rready, bready, wlast = 0;
  - rd_done, wr_done, err, busy = 0;
  - rd_line = 0 and counters = 0.
- Reset mid-burst abandons the transaction; no done pulse is generated.
- All AXI outputs are registered-state decodes. There is no combinational path from an AXI ready/valid to our valid outputs.
- rd_ready and wr_ready are combinational from rd_req/wr_req and state.
- arvalid/awvalid assert the cycle after acceptance and hold until the ready handshake. The address is stable while valid.
- wvalid/wdata/wlast are stable while wready=0.
- Read latency with zero-wait slave: accept at cycle 0, ar handshake at cycle 1, beats at cycles 2..BEATS+1, rd_done at BEATS+2.
- Write latency with zero-wait slave: aw at 1, beats at 2..BEATS+1, b at BEATS+2, wr_done at BEATS+3.
- Back-to-back: a new request can be accepted in the same cycle as the previous done pulse (state is IDLE).

## Test plan
- Read from an identity responder (rdata = base + 4·beat), rd_addr=0x0000_1004: araddr=0x1000, arlen=7; rd_line words 0..7 = 0x1000..0x101C; one rd_done pulse at cycle 10; err=0.
- Write wr_line = {0x77777777, …, 0x00000000} to 0x2000: awlen=7; beats emitted low word first (0x0,0x11111111,…); wlast only on beat 7; slave-reconstructed line equals wr_line; wr_done after bvalid.
- rd_req and wr_req asserted together in IDLE: read accepted first (rd_ready=1, wr_ready=0); write accepted in the cycle of rd_done if still held.
- Random arready/awready/wready/rvalid/bvalid stalls (0–5 cycles): valids and payload held stable; same data results as the zero-wait runs.
- Slave returns rlast on beat 3 with arlen=7: transition to IDLE, rd_done and err pulse together.
- rst asserted at write beat 4: next cycle wvalid=0 and state IDLE; no wr_done; a subsequent read completes normally.

Source files
------------

// File: rtl/axi3_line_master.sv
// rtl/axi3_line_master.sv - AXI3 burst master moving whole cache lines over one INCR burst
module axi3_line_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  // line request side
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_ready,
  output logic [LINE_WIDTH-1:0]   rd_line,
  output logic                    rd_done,
  input  logic                    wr_req,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [LINE_WIDTH-1:0]   wr_line,
  output logic                    wr_ready,
  output logic                    wr_done,
  output logic                    busy,
  output logic                    err,
  // AXI3 read address channel
  output logic [3:0]              arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [3:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  // AXI3 read data channel
  input  logic [3:0]              rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  // AXI3 write address channel
  output logic [3:0]              awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI3 write data channel
  output logic [3:0]              wid,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  // AXI3 write response channel
  input  logic [3:0]              bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int         BEATS     = LINE_WIDTH / DATA_WIDTH;
  localparam int         OFFS      = $clog2(LINE_WIDTH / 8);
  localparam int         SEL_W     = $clog2(LINE_WIDTH);
  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);
  localparam logic [2:0] BEAT_SIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0]   rd_line_q, rd_line_d;
  logic [LINE_WIDTH-1:0]   wbuf_q, wbuf_d;
  logic                    rd_done_q, rd_done_d;
  logic                    wr_done_q, wr_done_d;
  logic                    err_q, err_d;

  logic                    last_beat;
  logic [SEL_W-1:0]        beat_sel;
  logic                    unused_inputs;

  assign last_beat = (cnt_q == LAST_BEAT);
  assign beat_sel  = SEL_W'(cnt_q) * SEL_W'(DATA_WIDTH);

  // Response ids/codes and the in-line offset bits of request addresses carry no information here
  assign unused_inputs = ^{rid, rresp, bid, bresp, rd_addr[OFFS-1:0], wr_addr[OFFS-1:0]};

  // State and datapath registers; reset abandons any burst without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      rd_line_q <= '0;
      wbuf_q    <= '0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rd_line_q <= rd_line_d;
      wbuf_q    <= wbuf_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      err_q     <= err_d;
    end
  end

  // Next state, beat counting, line assembly and done/err pulse generation
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rd_line_d = rd_line_q;
    wbuf_d    = wbuf_q;
    rd_done_d = 1'b0;
    wr_done_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          state_d = RD_ADDR;
          addr_d  = {rd_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
          cnt_d   = '0;
        end else if (wr_req) begin
          state_d = WR_ADDR;
          addr_d  = {wr_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
          cnt_d   = '0;
          wbuf_d  = wr_line;
        end
      end
      RD_ADDR: if (arready) state_d = RD_DATA;
      RD_DATA: begin
        if (rvalid) begin
          rd_line_d[beat_sel +: DATA_WIDTH] = rdata;
          cnt_d = cnt_q + 4'd1;
          // Either end marker closes the burst; disagreement between them is a protocol error
          if (rlast || last_beat) begin
            state_d   = IDLE;
            rd_done_d = 1'b1;
            err_d     = (rlast != last_beat);
          end
        end
      end
      WR_ADDR: if (awready) state_d = WR_DATA;
      WR_DATA: begin
        if (wready) begin
          cnt_d = cnt_q + 4'd1;
          if (last_beat) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bvalid) begin
          state_d   = IDLE;
          wr_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel valids/readies decoded purely from registered state (request readies excepted)
  always_comb begin
    rd_ready = 1'b0;
    wr_ready = 1'b0;
    arvalid  = 1'b0;
    rready   = 1'b0;
    awvalid  = 1'b0;
    wvalid   = 1'b0;
    wlast    = 1'b0;
    bready   = 1'b0;
    case (state_q)
      IDLE: begin
        rd_ready = rd_req;
        wr_ready = wr_req && !rd_req;
      end
      RD_ADDR: arvalid = 1'b1;
      RD_DATA: rready  = 1'b1;
      WR_ADDR: awvalid = 1'b1;
      WR_DATA: begin
        wvalid = 1'b1;
        wlast  = last_beat;
      end
      WR_RESP: bready = 1'b1;
      default: ;
    endcase
  end

  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign arlen   = LAST_BEAT;
  assign awlen   = LAST_BEAT;
  assign arsize  = BEAT_SIZE;
  assign awsize  = BEAT_SIZE;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arid    = '0;
  assign awid    = '0;
  assign wid     = '0;
  assign arlock  = '0;
  assign awlock  = '0;
  assign arcache = '0;
  assign awcache = '0;
  assign arprot  = '0;
  assign awprot  = '0;
  assign wstrb   = '1;
  assign wdata   = wbuf_q[beat_sel +: DATA_WIDTH];

  assign rd_line = rd_line_q;
  assign rd_done = rd_done_q;
  assign wr_done = wr_done_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_axi3_line_master.sv
// tb/tb_axi3_line_master.sv - scoreboard bench for axi3_line_master with a stalling AXI3 slave model
module tb_axi3_line_master;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LW    = 256;
  localparam int BEATS = LW / DW;

  typedef struct { logic [AW-1:0] addr; logic [3:0] len; } addr_exp_t;
  typedef struct { logic [LW-1:0] line; logic err; } rd_exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rd_req, wr_req, rd_ready, wr_ready, rd_done, wr_done, busy, err;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [LW-1:0] rd_line, wr_line;
  logic [3:0] arid, arlen, awid, awlen, wid, rid, bid, arcache, awcache;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
  logic [AW-1:0] araddr, awaddr;
  logic arvalid, arready, rvalid, rready, rlast, awvalid, awready;
  logic wvalid, wready, wlast, bvalid, bready;
  logic [DW-1:0] rdata, wdata;
  logic [DW/8-1:0] wstrb;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // scoreboard queues and bench-side model of rd_line
  addr_exp_t exp_ar_q[$];
  addr_exp_t exp_aw_q[$];
  rd_exp_t   exp_rd_q[$];
  logic [LW-1:0] exp_wr_q[$];
  logic [LW-1:0] model_rd_line;

  // slave configuration
  int stall_max = 0;
  int early_beat = -1;
  bit drop_rlast = 1'b0;

  // slave state and observation records
  bit ar_wait, aw_wait, w_wait, r_active, b_pending;
  logic [AW-1:0] ar_sv_addr, aw_sv_addr, r_base;
  logic [3:0] ar_sv_len, aw_sv_len;
  logic [DW-1:0] w_sv_data;
  logic w_sv_last;
  int ar_stall, aw_stall, w_stall, r_stall, b_stall;
  int r_beat, r_len, w_beat, w_len;
  logic [LW-1:0] w_cap, w_done_line;
  int ar_hs_cyc, aw_hs_cyc, b_hs_cyc;
  int rd_done_cnt = 0, wr_done_cnt = 0, rd_done_cyc = 0, wr_done_cyc = 0;

  axi3_line_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_line(rd_line), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_line(wr_line), .wr_ready(wr_ready), .wr_done(wr_done),
    .busy(busy), .err(err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int rnd_stall();
    if (stall_max == 0) return 0;
    return int'($urandom_range(stall_max, 0));
  endfunction

  // Slave model and output monitor: decisions made at negedge take effect at the next posedge
  initial begin
    arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0; bvalid = 0;
    rdata = '0; rid = '0; rresp = '0; bid = '0; bresp = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0; bvalid = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0; r_active = 0; b_pending = 0; w_beat = 0;
      end else begin
        // R channel (before AR so a fresh burst starts next cycle)
        rvalid = 0; rlast = 0;
        if (r_active) begin
          if (r_stall > 0) r_stall--;
          else begin
            rvalid = 1;
            rdata = r_base + 32'(4 * r_beat);
            rlast = drop_rlast ? 1'b0 : (r_beat == r_len || r_beat == early_beat);
            if (rready === 1'b1) begin
              if (r_beat == r_len || rlast) r_active = 0;
              r_beat++;
              r_stall = rnd_stall();
            end
          end
        end
        // AR channel
        arready = 0;
        if (ar_wait) begin
          vectors++;
          if (arvalid !== 1'b1 || araddr !== ar_sv_addr || arlen !== ar_sv_len) begin
            miscompares++;
            $display("FAIL ar_stable: arvalid=%b araddr=%h arlen=%0d, required 1 %h %0d", arvalid, araddr, arlen, ar_sv_addr, ar_sv_len);
          end
        end
        if (arvalid === 1'b1) begin
          if (!ar_wait) ar_stall = rnd_stall();
          if (ar_stall == 0) begin
            addr_exp_t a;
            arready = 1; ar_wait = 0; ar_hs_cyc = cyc;
            vectors++;
            if (exp_ar_q.size() == 0) begin
              miscompares++;
              $display("FAIL ar_unexpected: araddr=%h, required no AR", araddr);
            end else begin
              a = exp_ar_q.pop_front();
              if (araddr !== a.addr || arlen !== a.len) begin
                miscompares++;
                $display("FAIL ar_fields: araddr=%h arlen=%0d, required %h %0d", araddr, arlen, a.addr, a.len);
              end
            end
            r_active = 1; r_base = araddr; r_beat = 0; r_len = int'(arlen); r_stall = rnd_stall();
          end else begin
            ar_stall--; ar_wait = 1; ar_sv_addr = araddr; ar_sv_len = arlen;
          end
        end else ar_wait = 0;
        // B channel (before W so the response follows the last beat)
        bvalid = 0;
        if (b_pending) begin
          if (b_stall > 0) b_stall--;
          else begin
            bvalid = 1; bresp = 2'b00;
            if (bready === 1'b1) begin b_pending = 0; b_hs_cyc = cyc; end
          end
        end
        // W channel
        wready = 0;
        if (w_wait) begin
          vectors++;
          if (wvalid !== 1'b1 || wdata !== w_sv_data || wlast !== w_sv_last) begin
            miscompares++;
            $display("FAIL w_stable: wvalid=%b wdata=%h wlast=%b, required 1 %h %b", wvalid, wdata, wlast, w_sv_data, w_sv_last);
          end
        end
        if (wvalid === 1'b1) begin
          if (!w_wait) w_stall = rnd_stall();
          if (w_stall == 0) begin
            wready = 1; w_wait = 0;
            if (w_beat < BEATS) w_cap[w_beat*DW +: DW] = wdata;
            vectors++;
            if (wlast !== (w_beat == w_len)) begin
              miscompares++;
              $display("FAIL wlast: beat %0d wlast=%b, required %b", w_beat, wlast, (w_beat == w_len));
            end
            w_beat++;
            if (wlast === 1'b1) begin
              b_pending = 1; b_stall = rnd_stall(); w_done_line = w_cap; w_beat = 0;
            end
          end else begin
            w_stall--; w_wait = 1; w_sv_data = wdata; w_sv_last = wlast;
          end
        end else w_wait = 0;
        // AW channel
        awready = 0;
        if (aw_wait) begin
          vectors++;
          if (awvalid !== 1'b1 || awaddr !== aw_sv_addr || awlen !== aw_sv_len) begin
            miscompares++;
            $display("FAIL aw_stable: awvalid=%b awaddr=%h awlen=%0d, required 1 %h %0d", awvalid, awaddr, awlen, aw_sv_addr, aw_sv_len);
          end
        end
        if (awvalid === 1'b1) begin
          if (!aw_wait) aw_stall = rnd_stall();
          if (aw_stall == 0) begin
            addr_exp_t a;
            awready = 1; aw_wait = 0; aw_hs_cyc = cyc;
            vectors++;
            if (exp_aw_q.size() == 0) begin
              miscompares++;
              $display("FAIL aw_unexpected: awaddr=%h, required no AW", awaddr);
            end else begin
              a = exp_aw_q.pop_front();
              if (awaddr !== a.addr || awlen !== a.len) begin
                miscompares++;
                $display("FAIL aw_fields: awaddr=%h awlen=%0d, required %h %0d", awaddr, awlen, a.addr, a.len);
              end
            end
            w_len = int'(awlen); w_beat = 0; w_cap = '0;
          end else begin
            aw_stall--; aw_wait = 1; aw_sv_addr = awaddr; aw_sv_len = awlen;
          end
        end else aw_wait = 0;
      end
      // done/err monitor
      if (rd_done === 1'b1) begin
        rd_exp_t e;
        rd_done_cnt++; rd_done_cyc = cyc;
        vectors++;
        if (exp_rd_q.size() == 0) begin
          miscompares++;
          $display("FAIL rd_done_unexpected: rd_done=1, required 0");
        end else begin
          e = exp_rd_q.pop_front();
          if (rd_line !== e.line || err !== e.err) begin
            miscompares++;
            $display("FAIL rd_result: line=%h err=%b, required line=%h err=%b", rd_line, err, e.line, e.err);
          end
        end
      end else if (err === 1'b1) begin
        vectors++; miscompares++;
        $display("FAIL err_alone: err=1 rd_done=%b, required err only with rd_done", rd_done);
      end
      if (wr_done === 1'b1) begin
        wr_done_cnt++; wr_done_cyc = cyc;
        vectors++;
        if (exp_wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL wr_done_unexpected: wr_done=1, required 0");
        end else begin
          logic [LW-1:0] l;
          l = exp_wr_q.pop_front();
          if (w_done_line !== l) begin
            miscompares++;
            $display("FAIL wr_line: slave got %h, required %h", w_done_line, l);
          end
        end
      end
    end
  end

  task automatic push_read(input logic [AW-1:0] addr);
    rd_exp_t e;
    logic [AW-1:0] base;
    int n;
    base = {addr[AW-1:5], 5'b0};
    n = (early_beat >= 0) ? early_beat + 1 : BEATS;
    for (int k = 0; k < n; k++) model_rd_line[k*DW +: DW] = base + 32'(4 * k);
    e.line = model_rd_line;
    e.err = (early_beat >= 0) || drop_rlast;
    exp_rd_q.push_back(e);
    exp_ar_q.push_back('{base, 4'(BEATS - 1)});
  endtask

  task automatic push_write(input logic [AW-1:0] addr, input logic [LW-1:0] line);
    exp_aw_q.push_back('{{addr[AW-1:5], 5'b0}, 4'(BEATS - 1)});
    exp_wr_q.push_back(line);
  endtask

  task automatic issue_read(input logic [AW-1:0] addr, output int acc);
    int n = 0;
    push_read(addr);
    @(posedge clk); #1;
    rd_req = 1; rd_addr = addr;
    forever begin
      @(negedge clk);
      if (rd_ready === 1'b1) break;
      if (++n > 200) begin
        vectors++; miscompares++;
        $display("FAIL rd_accept_timeout: rd_ready=%b, required 1", rd_ready);
        break;
      end
    end
    acc = cyc;
    @(posedge clk); #1;
    rd_req = 0; rd_addr = $urandom;
  endtask

  task automatic issue_write(input logic [AW-1:0] addr, input logic [LW-1:0] line, output int acc);
    int n = 0;
    push_write(addr, line);
    @(posedge clk); #1;
    wr_req = 1; wr_addr = addr; wr_line = line;
    forever begin
      @(negedge clk);
      if (wr_ready === 1'b1) break;
      if (++n > 200) begin
        vectors++; miscompares++;
        $display("FAIL wr_accept_timeout: wr_ready=%b, required 1", wr_ready);
        break;
      end
    end
    acc = cyc;
    @(posedge clk); #1;
    wr_req = 0; wr_addr = $urandom; wr_line = ~line;
  endtask

  task automatic wait_rd(input int target);
    int n = 0;
    while (rd_done_cnt < target) begin
      @(negedge clk);
      if (++n > 500) begin
        vectors++; miscompares++;
        $display("FAIL rd_done_timeout: count=%0d, required %0d", rd_done_cnt, target);
        break;
      end
    end
  endtask

  task automatic wait_wr(input int target);
    int n = 0;
    while (wr_done_cnt < target) begin
      @(negedge clk);
      if (++n > 500) begin
        vectors++; miscompares++;
        $display("FAIL wr_done_timeout: count=%0d, required %0d", wr_done_cnt, target);
        break;
      end
    end
  endtask

  function automatic logic [LW-1:0] stripe_line();
    logic [LW-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*DW +: DW] = 32'(k) * 32'h1111_1111;
    return l;
  endfunction

  function automatic logic [LW-1:0] random_line();
    logic [LW-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*DW +: DW] = $urandom;
    return l;
  endfunction

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, arvalid, awvalid, wvalid, rready, bready, wlast} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/arv/awv/wv/rr/br/wl=%b, required 0000000", {busy, arvalid, awvalid, wvalid, rready, bready, wlast});
    end
    vectors++;
    if ({rd_done, wr_done, err, rd_ready, wr_ready} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_pulses: rd_done/wr_done/err/rd_ready/wr_ready=%b, required 00000", {rd_done, wr_done, err, rd_ready, wr_ready});
    end
    vectors++;
    if (rd_line !== '0) begin
      miscompares++;
      $display("FAIL reset_rd_line: %h, required 0", rd_line);
    end
    vectors++;
    if (arsize !== 3'd2 || awsize !== 3'd2 || arburst !== 2'b01 || awburst !== 2'b01 || wstrb !== 4'hF) begin
      miscompares++;
      $display("FAIL const_fields: arsize=%0d awsize=%0d arburst=%b awburst=%b wstrb=%h, required 2 2 01 01 f", arsize, awsize, arburst, awburst, wstrb);
    end
    vectors++;
    if ({arid, awid, wid, arlock, awlock, arcache, awcache, arprot, awprot} !== '0) begin
      miscompares++;
      $display("FAIL zero_fields: ids/lock/cache/prot nonzero, required 0");
    end
    @(posedge clk); #1;
    rst = 0;
    model_rd_line = '0;
  endtask

  task automatic test_read_basic();
    int acc, n0;
    stall_max = 0; early_beat = -1; drop_rlast = 0;
    n0 = rd_done_cnt;
    issue_read(32'h0000_1004, acc);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_busy: busy=%b, required 1", busy);
    end
    wait_rd(n0 + 1);
    vectors++;
    if (ar_hs_cyc !== acc + 1) begin
      miscompares++;
      $display("FAIL ar_latency: cycle %0d, required %0d", ar_hs_cyc - acc, 1);
    end
    vectors++;
    if (rd_done_cyc !== acc + BEATS + 2) begin
      miscompares++;
      $display("FAIL rd_latency: rd_done at +%0d, required +%0d", rd_done_cyc - acc, BEATS + 2);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (rd_done_cnt !== n0 + 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_pulse_count: pulses=%0d busy=%b, required 1 0", rd_done_cnt - n0, busy);
    end
  endtask

  task automatic test_write_basic();
    int acc, n0;
    stall_max = 0;
    n0 = wr_done_cnt;
    issue_write(32'h0000_2000, stripe_line(), acc);
    wait_wr(n0 + 1);
    vectors++;
    if (aw_hs_cyc !== acc + 1) begin
      miscompares++;
      $display("FAIL aw_latency: +%0d, required +1", aw_hs_cyc - acc);
    end
    vectors++;
    if (b_hs_cyc !== acc + BEATS + 2) begin
      miscompares++;
      $display("FAIL b_latency: +%0d, required +%0d", b_hs_cyc - acc, BEATS + 2);
    end
    vectors++;
    if (wr_done_cyc !== acc + BEATS + 3) begin
      miscompares++;
      $display("FAIL wr_latency: wr_done at +%0d, required +%0d", wr_done_cyc - acc, BEATS + 3);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (wr_done_cnt !== n0 + 1) begin
      miscompares++;
      $display("FAIL wr_pulse_count: pulses=%0d, required 1", wr_done_cnt - n0);
    end
  endtask

  task automatic test_both_requests();
    int n = 0, r0, w0;
    logic [LW-1:0] line;
    stall_max = 0;
    r0 = rd_done_cnt; w0 = wr_done_cnt;
    line = random_line();
    push_read(32'h0000_3000);
    push_write(32'h0000_401C, line);
    @(posedge clk); #1;
    rd_req = 1; rd_addr = 32'h0000_3000;
    wr_req = 1; wr_addr = 32'h0000_401C; wr_line = line;
    @(negedge clk);
    vectors++;
    if (rd_ready !== 1'b1 || wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL arbitration: rd_ready=%b wr_ready=%b, required 1 0", rd_ready, wr_ready);
    end
    @(posedge clk); #1;
    rd_req = 0;
    forever begin
      @(negedge clk);
      if (wr_ready === 1'b1) break;
      if (++n > 200) begin
        vectors++; miscompares++;
        $display("FAIL held_write_timeout: wr_ready=%b, required 1", wr_ready);
        break;
      end
    end
    vectors++;
    if (rd_done !== 1'b1) begin
      miscompares++;
      $display("FAIL back_to_back: rd_done=%b at write accept, required 1", rd_done);
    end
    @(posedge clk); #1;
    wr_req = 0; wr_line = ~line;
    wait_wr(w0 + 1);
    vectors++;
    if (rd_done_cnt !== r0 + 1) begin
      miscompares++;
      $display("FAIL both_rd_count: %0d, required 1", rd_done_cnt - r0);
    end
  endtask

  task automatic test_stalls();
    int acc, r0, w0;
    stall_max = 5;
    r0 = rd_done_cnt; w0 = wr_done_cnt;
    issue_read(32'h0000_1004, acc);
    wait_rd(r0 + 1);
    issue_write(32'h0000_2000, stripe_line(), acc);
    wait_wr(w0 + 1);
    for (int i = 0; i < 4; i++) begin
      issue_read($urandom, acc);
      wait_rd(r0 + 2 + i);
      issue_write($urandom, random_line(), acc);
      wait_wr(w0 + 2 + i);
    end
    vectors++;
    if (rd_done_cnt !== r0 + 5 || wr_done_cnt !== w0 + 5) begin
      miscompares++;
      $display("FAIL stall_counts: rd=%0d wr=%0d, required 5 5", rd_done_cnt - r0, wr_done_cnt - w0);
    end
    stall_max = 0;
  endtask

  task automatic test_early_rlast();
    int acc, r0;
    stall_max = 0; early_beat = 3;
    r0 = rd_done_cnt;
    issue_read(32'h0000_5000, acc);
    wait_rd(r0 + 1);
    vectors++;
    if (rd_done_cyc !== acc + 2 + 4) begin
      miscompares++;
      $display("FAIL early_rlast_latency: +%0d, required +6", rd_done_cyc - acc);
    end
    early_beat = -1; drop_rlast = 1;
    issue_read(32'h0000_6010, acc);
    wait_rd(r0 + 2);
    drop_rlast = 0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || rready !== 1'b0) begin
      miscompares++;
      $display("FAIL err_idle: busy=%b rready=%b, required 0 0", busy, rready);
    end
  endtask

  task automatic test_reset_midwrite();
    int acc, n = 0, w0, r0;
    logic [LW-1:0] line;
    stall_max = 0;
    w0 = wr_done_cnt; r0 = rd_done_cnt;
    line = random_line();
    issue_write(32'h0000_7000, line, acc);
    while (w_beat != 4) begin
      @(posedge clk); #1;
      if (++n > 100) begin
        vectors++; miscompares++;
        $display("FAIL beat4_timeout: w_beat=%0d, required 4", w_beat);
        break;
      end
    end
    vectors++;
    if (wvalid !== 1'b1 || wdata !== line[4*DW +: DW]) begin
      miscompares++;
      $display("FAIL beat4_data: wvalid=%b wdata=%h, required 1 %h", wvalid, wdata, line[4*DW +: DW]);
    end
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (wvalid !== 1'b0 || busy !== 1'b0 || wlast !== 1'b0) begin
      miscompares++;
      $display("FAIL midwrite_reset: wvalid=%b busy=%b wlast=%b, required 0 0 0", wvalid, busy, wlast);
    end
    @(posedge clk); #1;
    rst = 0;
    exp_wr_q.delete();
    model_rd_line = '0;
    repeat (20) @(negedge clk);
    vectors++;
    if (wr_done_cnt !== w0) begin
      miscompares++;
      $display("FAIL abandoned_write: wr_done pulses=%0d, required 0", wr_done_cnt - w0);
    end
    issue_read(32'h0000_1004, acc);
    wait_rd(r0 + 1);
    vectors++;
    if (rd_done_cyc !== acc + BEATS + 2) begin
      miscompares++;
      $display("FAIL post_reset_read: +%0d, required +%0d", rd_done_cyc - acc, BEATS + 2);
    end
  endtask

  initial begin
    rst = 1; rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0; wr_line = '0;
    model_rd_line = '0;
    test_reset();
    test_read_basic();
    test_write_basic();
    test_both_requests();
    test_stalls();
    test_early_rlast();
    test_reset_midwrite();
    repeat (5) @(negedge clk);
    vectors++;
    if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_results: rd=%0d wr=%0d pending, required 0 0", exp_rd_q.size(), exp_wr_q.size());
    end
    vectors++;
    if (exp_ar_q.size() != 0 || exp_aw_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_addr: ar=%0d aw=%0d pending, required 0 0", exp_ar_q.size(), exp_aw_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
